latch_bus_sequencer: RTL

LATCH_BUS_SEQUENCER -- requirements
Module: latch_bus_sequencer

---
 rtl/latch_seq_pkg.sv | 16 +
 rtl/latch_bus_sequencer_rr_arbiter.sv | 31 +++
 rtl/latch_bus_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/latch_seq_pkg.sv
// Shared definitions for the latch bus sequencer.
// Holds the write FSM state encoding and the default sizing constants.
package latch_seq_pkg;

    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned N_LATCH_DEF  = 4;
    localparam int unsigned LE_WIDTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/latch_bus_sequencer_rr_arbiter.sv
// Round-robin arbiter.
// Ports: req    - request vector
//        ptr    - index holding highest priority this cycle
//        gnt_c  - combinational one-hot grant (all zero when no request)
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt_c
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan requesters starting at ptr, wrapping modulo N_REQ; first hit wins.
    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx = PW'((int'(ptr) + i) % int'(N_REQ));
            if (!found && req[idx]) begin
                gnt_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_bus_sequencer.sv
// Write sequencer for a bus of transparent latches plus read-side output
// enable control with break-before-make dead time.
// Ports: CLK/RST        - clock, async active-high reset
//        REQ/REQ_ADDR/REQ_DATA - per-requester write request, target, byte
//        GNT/DONE/BUSY  - grant, completion pulse, sequencer busy
//        BUS_D/LE       - shared latch data bus, per-latch enables
//        OE_SEL/OE_EN   - read-bus latch select and enable
//        nOE            - per-latch output enables, active low
module latch_bus_sequencer
    import latch_seq_pkg::*;
#(
    parameter  int unsigned N_REQ    = N_REQ_DEF,
    parameter  int unsigned N_LATCH  = N_LATCH_DEF,
    parameter  int unsigned LE_WIDTH = LE_WIDTH_DEF,
    localparam int unsigned AW       = (N_LATCH > 1) ? $clog2(N_LATCH) : 1,
    localparam int unsigned PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned CW       = (LE_WIDTH > 1) ? $clog2(LE_WIDTH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ*AW-1:0]   REQ_ADDR,
    input  logic [N_REQ*8-1:0]    REQ_DATA,
    output logic [N_REQ-1:0]      GNT,
    output logic [N_REQ-1:0]      DONE,
    output logic                  BUSY,
    output logic [7:0]            BUS_D,
    output logic [N_LATCH-1:0]    LE,
    input  logic [AW-1:0]         OE_SEL,
    input  logic                  OE_EN,
    output logic [N_LATCH-1:0]    nOE
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic [7:0]         bus_d_q, bus_d_d;
    logic [N_LATCH-1:0] le_q, le_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [N_LATCH-1:0] tgt_q, tgt_d;
    logic [N_LATCH-1:0] noe_q, noe_d;

    logic [N_REQ-1:0]   arb_gnt_c;
    logic [PW-1:0]      win_idx;
    logic [AW-1:0]      win_addr;
    logic [7:0]         win_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req   (REQ),
        .ptr   (ptr_q),
        .gnt_c (arb_gnt_c)
    );

    // Pull index, address and data of the arbitration winner.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_gnt_c[i]) begin
                win_idx  = PW'(i);
                win_addr = REQ_ADDR[i*AW +: AW];
                win_data = REQ_DATA[i*8 +: 8];
            end
        end
    end

    // Write FSM; outputs are computed for the next state so they register
    // aligned with the state they belong to.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        bus_d_d = bus_d_q;
        le_d    = le_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|REQ) begin
                    state_d = ST_SETUP;
                    gnt_d   = arb_gnt_c;
                    addr_d  = win_addr;
                    bus_d_d = win_data;
                    ptr_d   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
                le_d    = N_LATCH'(1) << addr_q;
            end
            ST_STROBE: begin
                if (cnt_q == CW'(LE_WIDTH - 1)) begin
                    state_d = ST_HOLD;
                    le_d    = '0;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                le_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                le_d    = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Read-side enables: any change of target inserts one all-high cycle.
    always_comb begin
        tgt_d = OE_EN ? ~(N_LATCH'(1) << OE_SEL) : '1;
        noe_d = (tgt_d != tgt_q) ? '1 : tgt_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            bus_d_q <= 8'h00;
            le_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            tgt_q   <= '1;
            noe_q   <= '1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            bus_d_q <= bus_d_d;
            le_q    <= le_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            tgt_q   <= tgt_d;
            noe_q   <= noe_d;
        end
    end

    assign GNT   = gnt_q;
    assign DONE  = done_q;
    assign BUSY  = busy_q;
    assign BUS_D = bus_d_q;
    assign LE    = le_q;
    assign nOE   = noe_q;

endmodule
